// File: rtl/rf_wb_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rf_wb_scheduler_pkg                                            |
// | Purpose  : Shared constants and helpers for the register-file write-back |
// |            scheduler: source indices, default widths, r0 address and    |
// |            the mod-3 source increment used by the round-robin arbiter.  |
// | Revision : 1.0  - initial release                                        |
// +--------------------------------------------------------------------------+
package rf_wb_scheduler_pkg;

  // Write-back source index, always in the range 0..NSRC-1.
  typedef logic [1:0] src_idx_t;

  localparam int       NSRC       = 3;
  localparam src_idx_t SRC_ALU    = 2'd0;
  localparam src_idx_t SRC_LOAD   = 2'd1;
  localparam src_idx_t SRC_MULDIV = 2'd2;

  localparam int DEF_DW  = 32;
  localparam int DEF_AW  = 5;
  localparam int R0_ADDR = 0;

  // Next source in round-robin order, wrapping 2 -> 0 so the value 3 never occurs.
  function automatic src_idx_t nextSrc(input src_idx_t idx);
    return (idx == SRC_MULDIV) ? SRC_ALU : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_scheduler_rr_arb3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb3                                                       |
// | Purpose  : 3-way round-robin arbiter. Search starts at rrPtr and wraps;  |
// |            on advance the pointer moves to one past the granted source. |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            req[2:0]   - request vector                                   |
// |            advance    - a grant was accepted this cycle                  |
// |            gnt[2:0]   - one-hot grant, forced to 0 while in reset        |
// |            gntIdx     - index of the granted source (valid when |gnt)    |
// |            rrPtr      - current search start pointer                     |
// | Revision : 1.0  - initial release                                        |
// +--------------------------------------------------------------------------+
module rr_arb3
  import rf_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] gnt,
  output src_idx_t   gntIdx,
  output src_idx_t   rrPtr
);

  src_idx_t r_ptr;

  always_comb begin
    src_idx_t cand;
    logic     found;
    gnt    = '0;
    gntIdx = SRC_ALU;
    cand   = r_ptr;
    found  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gntIdx    = cand;
        found     = 1'b1;
      end
      cand = nextSrc(cand);
    end
    // No source may see ready while the block is held in reset.
    if (!rst_n) begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SRC_ALU;
    end else if (advance) begin
      r_ptr <= nextSrc(gntIdx);
    end
  end

  assign rrPtr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rf_wb_scheduler                                               |
// | Purpose  : Shares the single register-file write port between the ALU,  |
// |            load and mul/div write-back sources (round-robin, valid/     |
// |            ready) and keeps a per-register busy scoreboard that stalls  |
// |            decode on RAW/WAW hazards.                                    |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            req_valid/req_ready/req_addr/req_data - write-back sources,  |
// |              source i packed at [i*W +: W]                               |
// |            iss_valid/iss_rd/iss_rs/iss_rt - decode issue                 |
// |            iss_stall - hazard flag from the busy vector only             |
// |            rf_wen/rf_waddr/rf_wdata - registered write port              |
// |            busy - scoreboard vector                                      |
// | Revision : 1.0  - initial release                                        |
// +--------------------------------------------------------------------------+
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      req_valid,
  output logic [NSRC-1:0]      req_ready,
  input  logic [NSRC*AW-1:0]   req_addr,
  input  logic [NSRC*DW-1:0]   req_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        iss_rs,
  input  logic [AW-1:0]        iss_rt,
  output logic                 iss_stall,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [(1<<AW)-1:0]   busy
);

  localparam int            NREG      = 1 << AW;
  localparam logic [AW-1:0] c_R0_ADDR = AW'(R0_ADDR);

  logic [NSRC-1:0] w_gnt;
  src_idx_t        w_gntIdx;
  src_idx_t        w_rrPtr;
  logic            w_hs;
  logic [AW-1:0]   w_selAddr;
  logic [DW-1:0]   w_selData;
  logic            w_wrReal;
  logic            w_stall;
  logic            w_issAccept;
  logic [NREG-1:0] w_busyNext;

  logic            r_wen;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [NREG-1:0] r_busy;

  rr_arb3 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (w_hs),
    .gnt     (w_gnt),
    .gntIdx  (w_gntIdx),
    .rrPtr   (w_rrPtr)
  );

  // The arbiter only grants valid sources, so any grant is a handshake.
  assign w_hs      = |w_gnt;
  assign req_ready = w_gnt;

  always_comb begin
    w_selAddr = req_addr[0 +: AW];
    w_selData = req_data[0 +: DW];
    case (w_gntIdx)
      SRC_LOAD: begin
        w_selAddr = req_addr[AW +: AW];
        w_selData = req_data[DW +: DW];
      end
      SRC_MULDIV: begin
        w_selAddr = req_addr[2*AW +: AW];
        w_selData = req_data[2*DW +: DW];
      end
      default: begin
        w_selAddr = req_addr[0 +: AW];
        w_selData = req_data[0 +: DW];
      end
    endcase
  end

  // The register file does not hardwire r0, so writes to it are swallowed here.
  assign w_wrReal = w_hs && (w_selAddr != c_R0_ADDR);

  // Stall depends on the current busy vector only, keeping req_valid off the
  // decode timing path; a same-cycle clear is seen one cycle later.
  assign w_stall     = r_busy[iss_rs] | r_busy[iss_rt] | r_busy[iss_rd];
  assign iss_stall   = w_stall;
  assign w_issAccept = iss_valid && !w_stall && (iss_rd != c_R0_ADDR);

  always_comb begin
    w_busyNext = r_busy;
    // Clear at the handshake: the RF bypass covers the cycle until rf_wen lands.
    if (w_wrReal) begin
      w_busyNext[w_selAddr] = 1'b0;
    end
    // Set after clear so a new (younger) producer wins a same-edge collision.
    if (w_issAccept) begin
      w_busyNext[iss_rd] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_wen  <= w_wrReal;
      r_busy <= w_busyNext;
      if (w_hs) begin
        r_waddr <= w_selAddr;
        r_wdata <= w_selData;
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy     = r_busy;

  logic w_unused;
  assign w_unused = ^w_rrPtr;

endmodule
`default_nettype wire

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Write-back scheduler for the 32x32 register file (2 read ports, 1 write port, write-to-read bypass inside the register file).
- Shares the single write port between three write-back sources: ALU, load unit and mul/div unit, using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register busy scoreboard, so decode stalls on RAW and WAW hazards against writes that have not yet been scheduled.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DW, 32, data width of the write data.
- AW, 5, register address width; the file holds 2**AW registers.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  3  per-source write request; bit0 ALU, bit1 LOAD, bit2 MULDIV.
- req_ready  out  3  per-source grant; a handshake occurs when valid&ready.
- req_addr  in  3*AW  per-source destination register, packed with source i at bits [i*AW +: AW].
- req_data  in  3*DW  per-source write data, packed the same way.
- iss_valid  in  1  decode issues an instruction that writes rd.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_rs  in  AW  first source register of the issuing instruction.
- iss_rt  in  AW  second source register of the issuing instruction.
- iss_stall  out  1  combinational hazard flag: busy[rs] | busy[rt] | busy[rd].
- rf_wen  out  1  register file write enable (registered).
- rf_waddr  out  AW  register file write address (registered).
- rf_wdata  out  DW  register file write data (registered).
- busy  out  2**AW  scoreboard vector, for debug and verification.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, round-robin pointer rr_ptr=0.
  - req_ready is 0 while rst_n is low.
- Arbitration (combinational):
  - Search order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
  - The first source with req_valid=1 gets req_ready=1. At most one ready bit is high per cycle.
  - No valid requests: req_ready=0.
- Pointer update: on a handshake, rr_ptr <= (granted index + 1) mod 3. Otherwise rr_ptr holds. rr_ptr never takes the value 3.
- Write stage (one-cycle latency):
  - On the edge where a handshake occurs: rf_waddr <= addr, rf_wdata <= data, rf_wen <= (addr != 0).
  - No handshake: rf_wen <= 0. rf_waddr and rf_wdata hold their values.
  - A handshake to register 0 completes normally but never produces a write strobe. The register file does not hardwire r0, so this block enforces r0 = 0.
- Scoreboard:
  - Set: on an edge with iss_valid=1, iss_stall=0 and iss_rd != 0, busy[iss_rd] <= 1.
  - Clear: on an edge with a handshake whose addr != 0, busy[addr] <= 0. The clear happens at the handshake, not at rf_wen; the register file bypass covers the following cycle.
  - Set and clear of the same register on the same edge: set wins, because the new producer is younger.
  - iss_valid while iss_stall=1 is ignored, and decode must hold the instruction.
  - busy[0] is constant 0.
  - iss_stall is a pure function of the current busy vector. It does not look at same-cycle handshakes, which avoids a combinational path from req_valid to decode.
- Source contract:
  - A source holds req_valid, addr and data stable until it sees ready.
  - The scheduler never drops an accepted request.
  - Any pattern of 3 persistently valid sources is serviced within 3 cycles (starvation-free).
- Reset mid-operation: all pending state is lost; busy clears and any in-flight rf_wen deasserts immediately.
- Handshake on a register whose busy bit is 0 (a producer not tracked by the scoreboard): write proceeds, no error; busy stays 0.

Decomposition:
- Shared package holds:
  - Source index constants SRC_ALU=0, SRC_LOAD=1, SRC_MULDIV=2 and NSRC=3.
  - Default widths DW and AW.
  - The r0 address constant.
- One sub-module is natural: rr_arb3, a 3-way round-robin arbiter with req[2:0], gnt[2:0], advance and rr_ptr state.
- The scoreboard and write stage stay in the top module.

Test Plan:
- Reset release, then idle: rf_wen=0, busy=0, req_ready=0, iss_stall=0 for 5 cycles.
- Single ALU write, addr=5, data=0xDEADBEEF, valid 1 cycle:
  - req_ready=3'b001 in the same cycle.
  - Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - The cycle after, rf_wen=0.
- All 3 sources valid continuously with addrs 1, 2, 3:
  - Grants go 001, 010, 100, 001, and so on.
  - rf_waddr sequence is 1, 2, 3, 1 with rf_wen high every cycle after the first.
- Write to r0 from LOAD with data=0xFFFFFFFF: req_ready[1]=1, rf_wen stays 0, busy[0]=0.
- Scoreboard RAW check:
  - Issue rd=7, which sets busy[7]=1.
  - Next issue with rs=7 gives iss_stall=1.
  - MULDIV handshake to addr 7 clears busy[7] on that edge, and iss_stall=0 the next cycle.
- Same-edge collision and mid-write reset:
  - Issue rd=9 on the same edge as an ALU handshake to addr 9: busy[9]=1 afterwards.
  - Assert rst_n=0 while rf_wen=1: rf_wen drops to 0 and busy=0 without waiting for a clock edge.
